// File: rtl/snn_pkg.sv
// Shared types and saturation limits for the SNN layer datapath.
package snn_pkg;

    typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, WRITE, DONE} seq_state_t;

    typedef enum logic [1:0] {NONE, OF, UF} sat_dir_t;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/sat16.sv
// Clamps the MAC accumulator to the 16-bit rail chosen by the first
// overflow/underflow seen during a dot product.
module sat16
    import snn_pkg::*;
(
    input  logic signed [15:0] acc,
    input  sat_dir_t           sat_dir,
    output logic signed [15:0] res
);

    function automatic logic signed [15:0] saturate(input logic signed [15:0] a,
                                                    input sat_dir_t d);
        case (d)
            OF:      return SAT_MAX;
            UF:      return SAT_MIN;
            default: return a;
        endcase
    endfunction

    assign res = saturate(acc, sat_dir);

endmodule

// File: rtl/mac_seq.sv
// Operand sequencer for the layer MAC: walks N_NEURONS dot products of
// N_INPUTS elements, then saturates and writes one result per neuron.
module mac_seq
    import snn_pkg::*;
#(
    parameter int N_INPUTS  = 784,
    parameter int N_NEURONS = 32,
    parameter int IN_AW     = 10,
    parameter int W_AW      = 15,
    parameter int OUT_AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [IN_AW-1:0]         in_addr,
    input  logic signed [7:0]        in_data,
    output logic [W_AW-1:0]          w_addr,
    input  logic signed [7:0]        w_data,
    output logic signed [7:0]        mac_a,
    output logic signed [7:0]        mac_b,
    output logic                     mac_clr_n,
    input  logic signed [15:0]       acc,
    input  logic                     of,
    input  logic                     uf,
    output logic                     res_we,
    output logic [OUT_AW-1:0]        res_addr,
    output logic signed [15:0]       res_data
);

    localparam int KW = $clog2(N_INPUTS);
    localparam logic [KW-1:0]     K_LAST = KW'(N_INPUTS - 1);
    localparam logic [OUT_AW-1:0] N_LAST = OUT_AW'(N_NEURONS - 1);

    seq_state_t          state;
    sat_dir_t            sat_dir;
    sat_dir_t            sat_dir_nxt;
    logic [KW-1:0]       k;
    logic [OUT_AW-1:0]   neuron;
    logic                rd_vld_p1;
    logic signed [15:0]  sat_val;

    // Read data lags the address by one cycle; the valid flag follows it so the
    // MAC only ever sees real elements and adds zero otherwise.
    assign mac_a = rd_vld_p1 ? in_data : '0;
    assign mac_b = rd_vld_p1 ? w_data  : '0;

    // The flags seen in the first MAC cycle belong to the clear, not a product.
    always_comb begin
        sat_dir_nxt = sat_dir;
        if (((state == MAC && k != '0) || state == DRAIN) && sat_dir == NONE) begin
            if (of)
                sat_dir_nxt = OF;
            else if (uf)
                sat_dir_nxt = UF;
        end
    end

    sat16 u_sat16 (
        .acc     (acc),
        .sat_dir (sat_dir_nxt),
        .res     (sat_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
            in_addr   <= '0;
            w_addr    <= '0;
            mac_clr_n <= 1'b0;
            rd_vld_p1 <= 1'b0;
            k         <= '0;
            neuron    <= '0;
            sat_dir   <= NONE;
        end else begin
            done      <= 1'b0;
            res_we    <= 1'b0;
            rd_vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    mac_clr_n <= 1'b0;
                    if (start) begin
                        state   <= CLR;
                        busy    <= 1'b1;
                        neuron  <= '0;
                        w_addr  <= '0;
                        in_addr <= '0;
                        k       <= '0;
                        sat_dir <= NONE;
                    end
                end
                CLR: begin
                    state     <= MAC;
                    mac_clr_n <= 1'b1;
                    in_addr   <= in_addr + IN_AW'(1);
                    w_addr    <= w_addr + W_AW'(1);
                    rd_vld_p1 <= 1'b1;
                end
                MAC: begin
                    sat_dir <= sat_dir_nxt;
                    if (k == K_LAST) begin
                        state <= DRAIN;
                    end else begin
                        k         <= k + KW'(1);
                        in_addr   <= in_addr + IN_AW'(1);
                        w_addr    <= w_addr + W_AW'(1);
                        rd_vld_p1 <= 1'b1;
                    end
                end
                // Last product has landed in acc; its flags are still eligible.
                DRAIN: begin
                    sat_dir  <= sat_dir_nxt;
                    res_data <= sat_val;
                    res_we   <= 1'b1;
                    res_addr <= neuron;
                    state    <= WRITE;
                end
                WRITE: begin
                    mac_clr_n <= 1'b0;
                    if (neuron == N_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        neuron  <= neuron + OUT_AW'(1);
                        state   <= CLR;
                        in_addr <= '0;
                        k       <= '0;
                        sat_dir <= NONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a behavioural MAC and 1-cycle-latency memories attached.
module tb_mac_seq;

    localparam int NI  = 4;
    localparam int NN  = 2;
    localparam int IAW = 3;
    localparam int WAW = 4;
    localparam int OAW = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy, done;
    logic [IAW-1:0] in_addr;
    logic [7:0]     in_data;
    logic [WAW-1:0] w_addr;
    logic [7:0]     w_data;
    logic [7:0]     mac_a, mac_b;
    logic           mac_clr_n;
    logic [15:0]    acc;
    logic           of, uf;
    logic           res_we;
    logic [OAW-1:0] res_addr;
    logic [15:0]    res_data;

    logic [7:0] in_mem [8];
    logic [7:0] w_mem  [16];

    int checks = 0;
    int errors = 0;

    mac_seq #(
        .N_INPUTS (NI),
        .N_NEURONS(NN),
        .IN_AW    (IAW),
        .W_AW     (WAW),
        .OUT_AW   (OAW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_clr_n(mac_clr_n),
        .acc      (acc),
        .of       (of),
        .uf       (uf),
        .res_we   (res_we),
        .res_addr (res_addr),
        .res_data (res_data)
    );

    always #10 clk = ~clk;

    // Synchronous memories
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
    end

    // Wrapping 16-bit MAC with registered per-addition overflow/underflow flags
    int mac_s;
    assign mac_s = int'($signed(acc)) + int'($signed(mac_a)) * int'($signed(mac_b));
    always @(posedge clk) begin
        if (!mac_clr_n) begin
            acc <= '0;
            of  <= 1'b0;
            uf  <= 1'b0;
        end else begin
            acc <= mac_s[15:0];
            of  <= (mac_s > 32767);
            uf  <= (mac_s < -32768);
        end
    end

    // Reference: true dot product with the first out-of-range partial sum choosing the rail
    function automatic logic [15:0] ref_dot(input int n);
        int a, s, dir;
        logic [31:0] sv;
        a = 0;
        dir = 0;
        for (int k = 0; k < NI; k++) begin
            s = a + int'($signed(in_mem[k])) * int'($signed(w_mem[n*NI + k]));
            if (dir == 0 && s > 32767) dir = 1;
            else if (dir == 0 && s < -32768) dir = 2;
            sv = s;
            a = int'($signed(sv[15:0]));
        end
        sv = a;
        if (dir == 1) return 16'h7FFF;
        if (dir == 2) return 16'h8000;
        return sv[15:0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          iv[4];
        int          wv[8];
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;
    vec_t tbl[5];

    int          nwe, ndone, done_cyc, busy_bad;
    int          ga[4], gc[4];
    logic [15:0] gd[4];
    int          ia[21], wa[21], ma[21], mb[21], cl[21], ac[21];

    task automatic load_mem(input vec_t v);
        for (int k = 0; k < NI; k++) in_mem[k] = 8'(v.iv[k]);
        for (int j = 0; j < NI*NN; j++) w_mem[j] = 8'(v.wv[j]);
        for (int k = NI; k < 8; k++) in_mem[k] = 8'($urandom_range(1, 255));
        for (int j = NI*NN; j < 16; j++) w_mem[j] = 8'($urandom_range(1, 255));
    endtask

    task automatic run_op(input bit extra_start);
        nwe = 0; ndone = 0; done_cyc = -1; busy_bad = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = extra_start && (c == 3 || c == 10);
            ia[c] = int'(in_addr);
            wa[c] = int'(w_addr);
            ma[c] = int'(mac_a);
            mb[c] = int'(mac_b);
            cl[c] = int'(mac_clr_n);
            ac[c] = int'(acc);
            if (res_we === 1'b1) begin
                if (nwe < 4) begin
                    ga[nwe] = int'(res_addr);
                    gd[nwe] = res_data;
                    gc[nwe] = c;
                end
                nwe++;
            end
            if (done === 1'b1) begin
                ndone++;
                done_cyc = c;
            end
            if (busy !== (c <= NN*(NI+3)+1)) busy_bad++;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [15:0] e0, input logic [15:0] e1);
        chk({tag, " we_count"}, nwe, 2);
        chk({tag, " addr0"}, ga[0], 0);
        chk({tag, " data0"}, int'(gd[0]), int'(e0));
        chk({tag, " we0_cycle"}, gc[0], NI+3);
        chk({tag, " addr1"}, ga[1], 1);
        chk({tag, " data1"}, int'(gd[1]), int'(e1));
        chk({tag, " we1_cycle"}, gc[1], 2*(NI+3));
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " done_cycle"}, done_cyc, NN*(NI+3)+1);
        chk({tag, " busy_window"}, busy_bad, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " res_we"}, int'(res_we), 0);
        chk({tag, " res_addr"}, int'(res_addr), 0);
        chk({tag, " res_data"}, int'(res_data), 0);
        chk({tag, " in_addr"}, int'(in_addr), 0);
        chk({tag, " w_addr"}, int'(w_addr), 0);
        chk({tag, " mac_a"}, int'(mac_a), 0);
        chk({tag, " mac_b"}, int'(mac_b), 0);
        chk({tag, " mac_clr_n"}, int'(mac_clr_n), 0);
    endtask

    initial begin
        int late_we, late_done;
        logic [15:0] e0, e1;

        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) in_mem[i] = '0;
        for (int i = 0; i < 16; i++) w_mem[i] = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        tbl[0].iv = '{1, 1, 1, 1};
        tbl[0].wv = '{2, 2, 2, 2, -3, -3, -3, -3};
        tbl[0].e0 = 16'h0008; tbl[0].e1 = 16'hFFF4;
        tbl[1].iv = '{127, 127, 127, 127};
        tbl[1].wv = '{127, 127, 127, 127, 127, 127, 127, 127};
        tbl[1].e0 = 16'h7FFF; tbl[1].e1 = 16'h7FFF;
        tbl[2].iv = '{127, 127, 127, 127};
        tbl[2].wv = '{-128, -128, -128, 127, 127, 127, -128, -128};
        tbl[2].e0 = 16'h8000; tbl[2].e1 = 16'hFF02;
        tbl[3].iv = '{5, -7, 3, 100};
        tbl[3].wv = '{50, -60, 70, -80, 0, 0, 0, 0};
        tbl[3].e0 = 16'hE430; tbl[3].e1 = 16'h0000;
        tbl[4].iv = '{127, 127, 127, 127};
        tbl[4].wv = '{0, 127, 127, 127, 127, 127, 4, 0};
        tbl[4].e0 = 16'h7FFF; tbl[4].e1 = 16'h7FFE;

        for (int i = 0; i < 5; i++) begin
            load_mem(tbl[i]);
            run_op(1'b0);
            check_run($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1);
            if (i == 0) begin
                for (int c = 1; c <= 5; c++) begin
                    chk($sformatf("n0 in_addr c%0d", c), ia[c], c-1);
                    chk($sformatf("n0 w_addr c%0d", c), wa[c], c-1);
                end
                for (int c = 8; c <= 12; c++) begin
                    chk($sformatf("n1 in_addr c%0d", c), ia[c], c-8);
                    chk($sformatf("n1 w_addr c%0d", c), wa[c], c-4);
                end
                chk("clr_n c1", cl[1], 0);
                chk("clr_n c8", cl[8], 0);
                for (int c = 2; c <= 5; c++) begin
                    chk($sformatf("clr_n c%0d", c), cl[c], 1);
                    chk($sformatf("mac_a c%0d", c), ma[c], 1);
                    chk($sformatf("mac_b c%0d", c), mb[c], 2);
                end
                for (int c = 6; c <= 8; c++) begin
                    chk($sformatf("gap mac_a c%0d", c), ma[c], 0);
                    chk($sformatf("gap mac_b c%0d", c), mb[c], 0);
                end
                chk("acc after clr", ac[9], 0);
            end
        end

        // Start re-pulsed while busy
        load_mem(tbl[0]);
        run_op(1'b1);
        check_run("handshake", tbl[0].e0, tbl[0].e1);

        // Reset during neuron 1 accumulation
        load_mem(tbl[0]);
        late_we = 0;
        late_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                check_idle_outputs("midrst");
                rst = 1'b0;
            end
            if (c >= 11 && res_we === 1'b1) late_we++;
            if (c >= 11 && done === 1'b1) late_done++;
        end
        chk("midrst late_we", late_we, 0);
        chk("midrst late_done", late_done, 0);
        run_op(1'b0);
        check_run("after_rst", tbl[0].e0, tbl[0].e1);

        // Random operands against the reference
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) in_mem[k] = 8'($urandom);
            for (int j = 0; j < 16; j++) w_mem[j] = 8'($urandom);
            e0 = ref_dot(0);
            e1 = ref_dot(1);
            run_op(1'b0);
            check_run($sformatf("rnd%0d", r), e0, e1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Sequencer sitting directly upstream of the MAC in the SNN datapath.
- For each neuron, fetches input-activation and weight bytes from synchronous ROM/RAM and drives the MAC operands and clr_n. It sticky-tracks overflow/underflow, then saturates and writes one 16-bit result per neuron.
- Runs N_NEURONS dot products of length N_INPUTS per start request.

Parameters:
- N_INPUTS, 784, dot-product length per neuron (≥2)
- N_NEURONS, 32, neurons per layer (≥1)
- IN_AW, 10, input-memory address width (2^IN_AW ≥ N_INPUTS)
- W_AW, 15, weight-memory address width (2^W_AW ≥ N_INPUTS*N_NEURONS)
- OUT_AW, 5, result address width (2^OUT_AW ≥ N_NEURONS)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  1-cycle pulse after the last result write
- in_addr  out  IN_AW  input-memory read address
- in_data  in  8  signed activation; valid 1 cycle after in_addr
- w_addr  out  W_AW  weight-memory read address
- w_data  in  8  signed weight; valid 1 cycle after w_addr
- mac_a  out  8  MAC operand a; 0 when no valid data
- mac_b  out  8  MAC operand b; 0 when no valid data
- mac_clr_n  out  1  MAC synchronous clear, active low
- acc  in  16  MAC accumulator
- of  in  1  MAC overflow flag (per-addition, registered)
- uf  in  1  MAC underflow flag (per-addition, registered)
- res_we  out  1  result write strobe
- res_addr  out  OUT_AW  neuron index of result
- res_data  out  16  saturated dot product

Behaviour:
- States: IDLE, CLR, MAC, DRAIN, WRITE, DONE (enum in package).
- IDLE:
  - mac_clr_n=0, which holds the MAC accumulator at 0.
  - On start, go to CLR; neuron=0, w_addr=0.
- CLR:
  - mac_clr_n=0; in_addr=0; k=0; clear sticky flags and sat_dir.
  - Go to MAC.
- MAC, N_INPUTS cycles:
  - mac_clr_n=1. Each cycle, issue address k+1 (in_addr, w_addr+1) while data for k is on in_data/w_data.
  - mac_a/mac_b = rd_valid ? data : 0. rd_valid is a 1-cycle-delayed copy of "address issued for a real element". It must be 0 for out-of-range address k=N_INPUTS.
  - The MAC therefore accumulates 0 in any idle cycle.
  - Leave after N_INPUTS cycles.
- DRAIN, 1 cycle:
  - mac_a/mac_b=0; acc now holds the final sum; of/uf reflect the last product.
  - Register res_data: if sat_dir==OF then 16'h7FFF; if sat_dir==UF then 16'h8000; else acc.
- WRITE, 1 cycle:
  - res_we=1, res_addr=neuron.
  - If neuron==N_NEURONS-1, go to DONE. Otherwise neuron++, keep running w_addr, go to CLR.
- DONE, 1 cycle: done=1; go to IDLE.
- Sticky flags:
  - Sampled in MAC cycles 2..N_INPUTS and in DRAIN.
  - The first flag seen sets sat_dir (OF or UF) and locks; later flags are ignored.
  - of and uf never assert together.
- Weight address is a running counter: no multiplier. w_addr for neuron n, element k = n*N_INPUTS+k.
- Per-neuron latency: N_INPUTS+3 cycles.
  - The first res_we occurs N_INPUTS+3 cycles after the start-sampling edge.
  - done occurs N_NEURONS*(N_INPUTS+3)+1 cycles after it.
- start while busy: ignored, with no effect on counters.
- Reset values:
  - state=IDLE; busy=0, done=0, res_we=0.
  - res_addr=0, res_data=0, in_addr=0, w_addr=0.
  - mac_a=0, mac_b=0, mac_clr_n=0.
- rst mid-operation:
  - Next cycle is IDLE with all outputs at reset values.
  - No further res_we; no done pulse.
- Overflow/underflow signalling is fully synchronous; no asynchronous paths.

Decomposition:
- Package snn_pkg:
  - seq_state_t enum.
  - sat_dir_t {NONE, OF, UF}.
  - Constants SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
- One sub-module sat16: combinational (acc, sat_dir) -> saturated 16-bit value.
- Counters and FSM stay in mac_seq.

Test Plan:
All tests use N_INPUTS=4, N_NEURONS=2, with the real mac instance attached and 1-cycle-latency memory models.
1. Basic sums: all in_data=1, weights 2 for neuron 0 and -3 for neuron 1; start -> res_we at cycle 7 (addr 0, data 8) and cycle 14 (addr 1, data 16'hFFF4); done at cycle 15; w_addr sequence 0..7.
2. Overflow: in_data=127, weights=127 -> third product overflows -> res_data=16'h7FFF for both neurons.
3. Underflow then overflow: in_data=127; weights -128,-128,-128,127,127 -> UF first -> res_data=16'h8000 (first flag locks).
4. Handshake: start pulsed again at cycles 3 and 10 -> ignored; busy continuous from cycle 1 to 15; exactly 2 res_we and 1 done.
5. Reset mid-op: rst asserted during neuron 1 MAC -> next cycle all outputs 0, mac_clr_n=0, no done; a new start then gives results identical to scenario 1.
6. Idle gating: between neurons (DRAIN/WRITE/CLR), mac_a=mac_b=0 and acc is 0 after CLR; neuron-1 result is independent of neuron 0 (e.g. weights 0 -> res_data=0).
